// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, talks to instruction memory with at
// most one request in flight, and presents fetched {PC, Instruction} pairs
// to the IF/ID register through a two-entry prefetch buffer.
module instr_fetch_stage #(
  parameter int                         ADDRESS_LEN     = 32,
  parameter int                         INSTRUCTION_LEN = 32,
  parameter logic [ADDRESS_LEN-1:0]     RESET_PC        = '0,
  parameter logic [INSTRUCTION_LEN-1:0] NOP_WORD        = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [ADDRESS_LEN-1:0]     imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [ADDRESS_LEN-1:0]     redirect_pc,
  output logic                       out_valid,
  output logic [ADDRESS_LEN-1:0]     PC,
  output logic [INSTRUCTION_LEN-1:0] Instruction
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [ADDRESS_LEN-1:0] ALIGN_MASK = ~{{(ADDRESS_LEN-2){1'b0}}, 2'b11};
  localparam logic [ADDRESS_LEN-1:0] PC_STEP    = {{(ADDRESS_LEN-3){1'b0}}, 3'b100};

  logic [1:0]                 state;
  logic [ADDRESS_LEN-1:0]     fetch_pc;
  logic [ADDRESS_LEN-1:0]     req_pc;
  logic [1:0]                 count;
  logic [ADDRESS_LEN-1:0]     head_pc;
  logic [INSTRUCTION_LEN-1:0] head_ins;
  logic [ADDRESS_LEN-1:0]     tail_pc;
  logic [INSTRUCTION_LEN-1:0] tail_ins;

  logic                       handshake;
  logic                       push;
  logic                       pop;
  logic [ADDRESS_LEN-1:0]     target_pc;

  // Request only from IDLE with a free slot; the reset term keeps imem_req low while rst is held.
  always_comb begin
    imem_req  = rst && (state == ST_IDLE) && (count != 2'd2) && !redirect;
    imem_addr = fetch_pc;
    handshake = imem_req && imem_gnt;
    push      = (state == ST_WAIT) && imem_rvalid && !redirect;
    pop       = out_valid && !stall && !redirect;
    target_pc = redirect_pc & ALIGN_MASK;
  end

  // Head of the buffer is shown directly; an empty buffer shows a bubble.
  always_comb begin
    out_valid   = (count != 2'd0);
    PC          = out_valid ? head_pc  : '0;
    Instruction = out_valid ? head_ins : NOP_WORD;
  end

  // Memory handshake FSM; a redirect while waiting turns the reply into one to discard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (handshake) state <= ST_WAIT;
        ST_WAIT: begin
          if (imem_rvalid)   state <= ST_IDLE;
          else if (redirect) state <= ST_DROP;
        end
        ST_DROP: if (imem_rvalid) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Fetch pointer: redirect wins, otherwise advance one word per accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= target_pc;
    end else if (handshake) begin
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  // Two-entry FIFO held as head/tail registers so the head needs no read mux.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= 2'd0;
      head_pc  <= '0;
      head_ins <= NOP_WORD;
      tail_pc  <= '0;
      tail_ins <= NOP_WORD;
    end else if (redirect) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_pc  <= req_pc;
            head_ins <= imem_rdata;
          end else begin
            tail_pc  <= req_pc;
            tail_ins <= imem_rdata;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_pc  <= tail_pc;
          head_ins <= tail_ins;
          count    <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_pc  <= req_pc;
            head_ins <= imem_rdata;
          end else begin
            head_pc  <= tail_pc;
            head_ins <= tail_ins;
            tail_pc  <= req_pc;
            tail_ins <= imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: a queue-level model of the
// prefetch buffer plus a latency-programmable memory responder.
module tb_instr_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;

  logic        req_a, req_b, valid_a, valid_b;
  logic [31:0] addr_a, addr_b, pc_a, pc_b, ins_a, ins_b;
  logic        req_m, valid_m;
  logic [31:0] addr_m, pc_m, ins_m;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat = 1;

  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  entry_t      q[$];
  logic [31:0] fpc;
  logic [31:0] m_req_pc;
  logic        outstanding;
  logic        doomed;
  logic        exp_req;
  logic        exp_valid;

  logic [31:0] seen_pc[$];
  int          seen_cyc[$];

  always #5 clk = ~clk;

  instr_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst_n),
    .imem_req(req_a), .imem_addr(addr_a), .imem_gnt(gnt & ~sel),
    .imem_rvalid(rvalid & ~sel), .imem_rdata(rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(valid_a), .PC(pc_a), .Instruction(ins_a)
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst_n),
    .imem_req(req_b), .imem_addr(addr_b), .imem_gnt(gnt & sel),
    .imem_rvalid(rvalid & sel), .imem_rdata(rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(valid_b), .PC(pc_b), .Instruction(ins_b)
  );

  assign req_m   = sel ? req_b   : req_a;
  assign addr_m  = sel ? addr_b  : addr_a;
  assign valid_m = sel ? valid_b : valid_a;
  assign pc_m    = sel ? pc_b    : pc_a;
  assign ins_m   = sel ? ins_b   : ins_a;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a << 1) ^ 32'hC3C3_0001;
  endfunction

  function automatic logic [31:0] seen_at(input int i);
    if (i < seen_pc.size()) return seen_pc[i];
    return 32'hDEAD_DEAD;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic checkOutput(input logic r);
    logic [31:0] exp_pc;
    logic [31:0] exp_ins;
    exp_valid = (q.size() != 0);
    exp_pc    = exp_valid ? q[0].pc  : 32'h0;
    exp_ins   = exp_valid ? q[0].ins : 32'h0;
    exp_req   = !outstanding && (q.size() < 2) && !r;
    chk("out_valid", {31'b0, valid_m}, {31'b0, exp_valid});
    chk("PC", pc_m, exp_pc);
    chk("Instruction", ins_m, exp_ins);
    chk("imem_req", {31'b0, req_m}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", addr_m, fpc);
  endtask

  task automatic model_reset();
    q.delete();
    fpc         = sel ? 32'hFFFF_FFFC : 32'h0;
    m_req_pc    = 32'h0;
    outstanding = 1'b0;
    doomed      = 1'b0;
    seen_pc.delete();
    seen_cyc.delete();
    cyc = 0;
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance model and memory.
  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc, input logic g);
    @(negedge clk);
    stall = s; redirect = r; redirect_pc = rpc; gnt = g;
    if (mem_busy && mem_cnt == 0) begin
      rvalid = 1'b1; rdata = word(mem_addr);
    end else begin
      rvalid = 1'b0; rdata = 32'hBAD0_BAD0;
    end
    #1;
    checkOutput(r);
    if (valid_m && !s && !r) begin
      seen_pc.push_back(pc_m);
      seen_cyc.push_back(cyc);
    end
    if (r) begin
      q.delete();
      if (outstanding) begin
        if (rvalid) begin outstanding = 1'b0; doomed = 1'b0; end
        else doomed = 1'b1;
      end
      fpc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (exp_valid && !s) void'(q.pop_front());
      if (outstanding && rvalid) begin
        if (!doomed) q.push_back('{pc: m_req_pc, ins: rdata});
        outstanding = 1'b0; doomed = 1'b0;
      end else if (exp_req && g) begin
        outstanding = 1'b1; m_req_pc = fpc; fpc = fpc + 32'd4;
      end
    end
    if (rvalid) mem_busy = 1'b0;
    else if (mem_busy && mem_cnt > 0) mem_cnt--;
    if (req_m && gnt) begin
      mem_busy = 1'b1; mem_addr = addr_m; mem_cnt = lat - 1;
    end
    cyc++;
  endtask

  // Asynchronous reset between edges; outputs must clear without waiting for a clock.
  task automatic doReset();
    @(negedge clk);
    #1;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0;
    #1;
    chk("rst_imem_req", {31'b0, req_m}, 32'h0);
    chk("rst_out_valid", {31'b0, valid_m}, 32'h0);
    chk("rst_PC", pc_m, 32'h0);
    chk("rst_Instruction", ins_m, 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    $display("[TB] start");
    model_reset();

    // Reset asserted while a request is outstanding, then fetch restarts at 0.
    lat = 3;
    doReset();
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    doReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t1_req_after_reset", {31'b0, req_m}, 32'h1);
    chk("t1_addr_after_reset", addr_m, 32'h0);

    // Sequential fetch with a 1-cycle memory.
    lat = 1;
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t2_pc0", seen_at(0), 32'h0);
    chk("t2_pc1", seen_at(1), 32'h4);
    chk("t2_pc2", seen_at(2), 32'h8);
    chk("t2_pc3", seen_at(3), 32'hC);

    // Stall fills the buffer, then two entries drain on consecutive cycles.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t3_req_full", {31'b0, req_m}, 32'h0);
    chk("t3_head_pc", pc_m, 32'h0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t3_first", seen_at(0), 32'h0);
    chk("t3_second", seen_at(1), 32'h4);
    chk("t3_back_to_back", (seen_cyc.size() > 1) ? seen_cyc[1] - seen_cyc[0] : 0, 32'd1);

    // Redirect while waiting; the stale reply arrives later and is discarded.
    lat = 3;
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, i == 2, 32'h0000_0103, 1'b1);
      if (i == 3) chk("t4_valid_after_redirect", {31'b0, valid_m}, 32'h0);
      if (i == 4) chk("t4_new_addr", addr_m, 32'h100);
    end
    chk("t4_first_pc", seen_at(0), 32'h100);

    // Redirect in the same cycle as the reply.
    lat = 2;
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, i == 2, 32'h0000_0040, 1'b1);
      if (i == 3) chk("t4b_addr", addr_m, 32'h40);
    end

    // Redirect together with stall on a full buffer.
    lat = 1;
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, i == 6, 32'h0000_0200, 1'b1);
      if (i == 7) chk("t5_flushed", {31'b0, valid_m}, 32'h0);
      if (i == 9) chk("t5_head_pc", pc_m, 32'h200);
    end

    // Mixed grant gaps, stalls and redirects on a 2-cycle memory.
    lat = 2;
    doReset();
    for (int i = 0; i < 40; i++)
      applyStimulus((i % 5 == 1) || (i % 7 == 3), (i == 17) || (i == 29),
                    (i == 17) ? 32'h0000_0300 : 32'h0000_1002, (i % 3) != 2);

    // Address wrap from the top of the address space.
    sel = 1'b1;
    lat = 1;
    doReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t6_first_addr", addr_m, 32'hFFFF_FFFC);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t6_pc0", seen_at(0), 32'hFFFF_FFFC);
    chk("t6_pc1", seen_at(1), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
